// File: rtl/capture_writer_if.sv
// Handshake, control and RAM-write bundle for capture_writer.
// master: the environment driving samples and control; slave: the writer.
interface capture_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  arm;
  logic                  trig;
  logic [ADDR_WIDTH-1:0] post_len;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] rd_start;
  logic                  done;

  modport master (
    output arm, trig, post_len, s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data, trig_addr, rd_start, done
  );

  modport slave (
    input  arm, trig, post_len, s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data, trig_addr, rd_start, done
  );
endinterface

// File: rtl/capture_writer.sv
// Circular-buffer capture writer: streams samples into a RAM ring while
// armed, locks the trigger position, collects post_len post-trigger samples
// and then freezes, reporting the oldest valid address for readback.
module capture_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  capture_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] post_len_q;
  logic                  hist_full;

  logic                  xfer;
  logic                  wrap;
  logic [ADDR_WIDTH-1:0] ptr_inc;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic                  last;

  // Handshake and pointer/counter arithmetic shared by the FSM.
  always_comb begin
    xfer    = bus.s_valid && bus.s_ready;
    wrap    = (wr_ptr == '1);
    ptr_inc = wr_ptr + ONE;
    cnt_inc = post_cnt + ONE;
    last    = xfer && (cnt_inc == post_len_q);
  end

  // Capture FSM with registered status outputs.
  // post_cnt stays 0 throughout ARMED, so cnt_inc==1 there and the trigger
  // sample itself can complete a post_len of 1 without a CAPTURE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      post_cnt      <= '0;
      post_len_q    <= ONE;
      hist_full     <= 1'b0;
      bus.s_ready   <= 1'b0;
      bus.trig_addr <= '0;
      bus.rd_start  <= '0;
      bus.done      <= 1'b0;
    end else if (bus.arm && (state != CAPTURE)) begin
      state       <= ARMED;
      wr_ptr      <= '0;
      post_cnt    <= '0;
      post_len_q  <= (bus.post_len == '0) ? ONE : bus.post_len;
      hist_full   <= 1'b0;
      bus.s_ready <= 1'b1;
      bus.done    <= 1'b0;
    end else begin
      unique case (state)
        ARMED: begin
          if (xfer) begin
            wr_ptr <= ptr_inc;
            if (wrap) hist_full <= 1'b1;
          end
          if (bus.trig) begin
            bus.trig_addr <= wr_ptr;
            post_cnt      <= xfer ? cnt_inc : '0;
            if (last) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.s_ready  <= 1'b0;
              bus.rd_start <= (hist_full || wrap) ? ptr_inc : '0;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (xfer) begin
            wr_ptr   <= ptr_inc;
            post_cnt <= cnt_inc;
            if (wrap) hist_full <= 1'b1;
            if (last) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.s_ready  <= 1'b0;
              bus.rd_start <= (hist_full || wrap) ? ptr_inc : '0;
            end
          end
        end
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM write port: each accepted sample is written one cycle later at the
  // pre-increment pointer; address and data hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= xfer;
      if (xfer) begin
        bus.wr_addr <= wr_ptr;
        bus.wr_data <= bus.s_data;
      end
    end
  end

endmodule

// File: tb/tb_capture_writer.sv
// Self-checking bench for capture_writer (ADDR_WIDTH=4, DATA_WIDTH=8).
// Each vector drives one cycle of inputs and lists the status outputs
// expected after that edge; accepted samples are queued as expected RAM
// writes and matched against the write strobe by a monitor.
module tb_capture_writer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  capture_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  capture_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       arm;
    logic       trig;
    logic       vld;
    logic [7:0] data;
    logic [3:0] plen;
    logic       acc;
    logic [3:0] addr;
    logic       e_ready;
    logic       e_done;
    logic [3:0] e_taddr;
    logic [3:0] e_rd;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [11:0] sb[$];
  logic [11:0] sb_head;
  vec_t        tbl[$];

  function automatic vec_t mk(input logic r, input logic a, input logic t,
                              input logic v, input logic [7:0] d,
                              input logic [3:0] pl, input logic acc,
                              input logic [3:0] ad, input logic er,
                              input logic ed, input logic [3:0] eta,
                              input logic [3:0] erd);
    vec_t x;
    x.rst = r; x.arm = a; x.trig = t; x.vld = v; x.data = d; x.plen = pl;
    x.acc = acc; x.addr = ad; x.e_ready = er; x.e_done = ed;
    x.e_taddr = eta; x.e_rd = erd;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    rst          = v.rst;
    bus.arm      = v.arm;
    bus.trig     = v.trig;
    bus.s_valid  = v.vld;
    bus.s_data   = v.data;
    bus.post_len = v.plen;
    if (v.acc) sb.push_back({v.addr, v.data});
    @(posedge clk);
    #1;
    chk("s_ready",   32'(bus.s_ready),   32'(v.e_ready));
    chk("done",      32'(bus.done),      32'(v.e_done));
    chk("trig_addr", 32'(bus.trig_addr), 32'(v.e_taddr));
    chk("rd_start",  32'(bus.rd_start),  32'(v.e_rd));
  endtask

  // Write monitor: every strobe must match the oldest queued sample.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        sb_head = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(sb_head[11:8]));
        chk("wr_data", 32'(bus.wr_data), 32'(sb_head[7:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic capture: 6 pre-trigger samples, trigger sample, 3 more -> done.
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 4'd4, 0, 4'd0, 1, 0, 4'd0, 4'd0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 0, 0, 1, 8'(8'h10 + i), 4'd0, 1, 4'(i), 1, 0, 4'd0, 4'd0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h16, 4'd0, 1, 4'd6, 1, 0, 4'd6, 4'd0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h17, 4'd0, 1, 4'd7, 1, 0, 4'd6, 4'd0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h18, 4'd0, 1, 4'd8, 1, 0, 4'd6, 4'd0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h19, 4'd0, 1, 4'd9, 0, 1, 4'd6, 4'd0));
    // In DONE: trig and s_valid ignored, done holds.
    tbl.push_back(mk(0, 0, 1, 1, 8'hAA, 4'd0, 0, 4'd0, 0, 1, 4'd6, 4'd0));

    // Reset and check reset values.
    apply(mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 4'd0, 0, 0, 4'd0, 4'd0));
    apply(mk(1, 1, 1, 1, 8'hFF, 4'd5, 0, 4'd0, 0, 0, 4'd0, 4'd0));
    chk("rst_wr_en",   32'(bus.wr_en),   32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);

    // trig and s_valid in IDLE: no effect.
    apply(mk(0, 0, 1, 1, 8'h55, 4'd0, 0, 4'd0, 0, 0, 4'd0, 4'd0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Wrap: 20 pre-trigger samples, trigger on 21st, post_len=3.
    apply(mk(0, 1, 0, 0, 8'h00, 4'd3, 0, 4'd0, 1, 0, 4'd6, 4'd0));
    for (int i = 0; i < 20; i++)
      apply(mk(0, 0, 0, 1, 8'(i + 1), 4'd0, 1, 4'(i), 1, 0, 4'd6, 4'd0));
    apply(mk(0, 0, 1, 1, 8'd21, 4'd0, 1, 4'd4, 1, 0, 4'd4, 4'd0));
    apply(mk(0, 0, 0, 1, 8'd22, 4'd0, 1, 4'd5, 1, 0, 4'd4, 4'd0));
    apply(mk(0, 0, 0, 1, 8'd23, 4'd0, 1, 4'd6, 0, 1, 4'd4, 4'd7));

    // Gaps: s_valid toggling, pointer advances only on transfers.
    apply(mk(0, 1, 0, 0, 8'h00, 4'd2, 0, 4'd0, 1, 0, 4'd4, 4'd7));
    for (int i = 0; i < 8; i++)
      apply(mk(0, 0, 0, (i % 2 == 0), 8'(8'h40 + i), 4'd0, (i % 2 == 0),
               4'(i / 2), 1, 0, 4'd4, 4'd7));
    apply(mk(0, 0, 1, 1, 8'h50, 4'd0, 1, 4'd4, 1, 0, 4'd4, 4'd7));
    apply(mk(0, 0, 0, 0, 8'h5F, 4'd0, 0, 4'd0, 1, 0, 4'd4, 4'd7));
    apply(mk(0, 0, 0, 1, 8'h51, 4'd0, 1, 4'd5, 0, 1, 4'd4, 4'd0));

    // arm during CAPTURE is ignored.
    apply(mk(0, 1, 0, 0, 8'h00, 4'd3, 0, 4'd0, 1, 0, 4'd4, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h60, 4'd0, 1, 4'd0, 1, 0, 4'd4, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h61, 4'd0, 1, 4'd1, 1, 0, 4'd4, 4'd0));
    apply(mk(0, 0, 1, 1, 8'h62, 4'd0, 1, 4'd2, 1, 0, 4'd2, 4'd0));
    apply(mk(0, 1, 0, 1, 8'h63, 4'd1, 1, 4'd3, 1, 0, 4'd2, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h64, 4'd0, 1, 4'd4, 0, 1, 4'd2, 4'd0));

    // post_len=0 behaves as 1: trigger sample completes the capture.
    apply(mk(0, 1, 0, 0, 8'h00, 4'd0, 0, 4'd0, 1, 0, 4'd2, 4'd0));
    apply(mk(0, 0, 1, 1, 8'h70, 4'd0, 1, 4'd0, 0, 1, 4'd0, 4'd0));

    // arm+trig together in ARMED: restart wins, trig_addr unchanged.
    apply(mk(0, 1, 0, 0, 8'h00, 4'd2, 0, 4'd0, 1, 0, 4'd0, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h80, 4'd0, 1, 4'd0, 1, 0, 4'd0, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h81, 4'd0, 1, 4'd1, 1, 0, 4'd0, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h82, 4'd0, 1, 4'd2, 1, 0, 4'd0, 4'd0));
    apply(mk(0, 1, 1, 0, 8'h00, 4'd2, 0, 4'd0, 1, 0, 4'd0, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h83, 4'd0, 1, 4'd0, 1, 0, 4'd0, 4'd0));
    apply(mk(0, 0, 1, 1, 8'h84, 4'd0, 1, 4'd1, 1, 0, 4'd1, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h85, 4'd0, 1, 4'd2, 0, 1, 4'd1, 4'd0));

    // Reset mid-CAPTURE after 2 of 4 post samples.
    apply(mk(0, 1, 0, 0, 8'h00, 4'd4, 0, 4'd0, 1, 0, 4'd1, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h90, 4'd0, 1, 4'd0, 1, 0, 4'd1, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h91, 4'd0, 1, 4'd1, 1, 0, 4'd1, 4'd0));
    apply(mk(0, 0, 1, 1, 8'h92, 4'd0, 1, 4'd2, 1, 0, 4'd2, 4'd0));
    apply(mk(0, 0, 0, 1, 8'h93, 4'd0, 1, 4'd3, 1, 0, 4'd2, 4'd0));
    apply(mk(1, 1, 1, 1, 8'hEE, 4'd4, 0, 4'd0, 0, 0, 4'd0, 4'd0));
    chk("midrst_wr_en",   32'(bus.wr_en),   32'd0);
    chk("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(bus.wr_data), 32'd0);
    apply(mk(0, 1, 0, 0, 8'h00, 4'd1, 0, 4'd0, 1, 0, 4'd0, 4'd0));
    apply(mk(0, 0, 1, 1, 8'hA0, 4'd0, 1, 4'd0, 0, 1, 4'd0, 4'd0));
    apply(mk(0, 0, 0, 0, 8'h00, 4'd0, 0, 4'd0, 0, 1, 4'd0, 4'd0));
    apply(mk(0, 0, 0, 1, 8'hBB, 4'd0, 0, 4'd0, 0, 1, 4'd0, 4'd0));

    @(negedge clk);
    chk("writes_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_writer.md
CAPTURE_WRITER -- requirements
Module: capture_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sample width in bits.
REQ-002 Parameter ADDR_WIDTH, default 9, buffer address width; buffer depth is 2^ADDR_WIDTH.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 arm  input  1  single-cycle pulse; starts a new capture.
REQ-006 trig  input  1  trigger event, sampled only in ARMED.
REQ-007 post_len  input  ADDR_WIDTH  post-trigger sample count, latched on arm.
REQ-008 s_data  input  DATA_WIDTH  incoming sample.
REQ-009 s_valid  input  1  s_data valid.
REQ-010 s_ready  output  1  block accepts a sample this cycle.
REQ-011 wr_en  output  1  RAM write strobe.
REQ-012 wr_addr  output  ADDR_WIDTH  RAM write address.
REQ-013 wr_data  output  DATA_WIDTH  RAM write data.
REQ-014 trig_addr  output  ADDR_WIDTH  buffer address of the trigger point.
REQ-015 rd_start  output  ADDR_WIDTH  oldest valid sample address, for the read-side address counter.
REQ-016 done  output  1  capture complete, buffer stable.

Function
REQ-017 The block SHALL implement FSM states IDLE, ARMED, CAPTURE, DONE.
REQ-018 A transfer SHALL occur when s_valid and s_ready are both 1; s_ready SHALL be 1 exactly in ARMED and CAPTURE.
REQ-019 Each transfer SHALL, one cycle later, drive wr_en=1, wr_addr=wr_ptr (pre-transfer value), wr_data=s_data; wr_en=0 otherwise.
REQ-020 wr_ptr SHALL increment by 1 per transfer, wrapping modulo 2^ADDR_WIDTH.
REQ-021 arm in IDLE, ARMED or DONE SHALL: go to ARMED, clear wr_ptr, hist_full and done, latch post_len (0 treated as 1); arm in CAPTURE SHALL be ignored.
REQ-022 In ARMED, hist_full SHALL set when wr_ptr wraps from 2^ADDR_WIDTH-1 to 0.
REQ-023 trig=1 in ARMED SHALL move to CAPTURE and latch trig_addr=wr_ptr; a transfer in the same cycle is the trigger sample and counts as post-sample 1.
REQ-024 In CAPTURE, a post counter SHALL count transfers; on the transfer making the count equal latched post_len, next state SHALL be DONE.
REQ-025 If post_len would overwrite the trigger sample (post_len reaching 2^ADDR_WIDTH is impossible by width), no special handling SHALL apply.
REQ-026 On entering DONE, done=1 and rd_start SHALL equal wr_ptr if hist_full (post-trigger wrap also sets hist_full), else 0; wr_ptr frozen.
REQ-027 trig outside ARMED and s_valid outside ARMED/CAPTURE SHALL have no effect.
REQ-028 arm and trig asserted together in ARMED: arm SHALL win (restart), trig ignored.
REQ-029 DONE SHALL persist until arm or rst.

Reset
REQ-030 rst SHALL override all inputs, including mid-capture: state IDLE, wr_ptr=0, post counter=0, hist_full=0.
REQ-031 Outputs after reset: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, trig_addr=0, rd_start=0, done=0.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-032 Basic: arm, post_len=4, samples 0x10..0x15 continuous, trig with 0x16, then 0x17..0x19 -> writes addr 0..9, trig_addr=6, done=1 cycle after 0x19 write, rd_start=0.
REQ-033 Wrap: arm, post_len=3, 20 samples before trig, trig with sample 21 -> hist_full=1, trig_addr=4, done after 23rd sample, rd_start=7.
REQ-034 Backpressure/gaps: s_valid toggled 1/0 -> wr_ptr advances only on transfers, wr_en pulses once per transfer, no duplicate addresses.
REQ-035 Ignored events: trig in IDLE/DONE, arm in CAPTURE, s_valid in DONE -> no state, pointer or write change.
REQ-036 Reset mid-CAPTURE after 2 of 4 post samples -> next cycle all outputs at reset values; subsequent arm starts at addr 0.
REQ-037 arm+trig same cycle in ARMED -> wr_ptr=0, state ARMED, trig_addr unchanged.
